// File: rtl/elevator_ctrl_fsm.sv
// elevator_ctrl_fsm: car-motion and door controller for a 4-floor elevator.
// Consumes position-relative request summaries (here/above/below) from the
// request-decode stage and drives the car position, door and motion flags.
// Ports:
//   clk, reset           - clock, synchronous active-high reset
//   ctrl_button_up[2:0]  - hall-up calls   ([0] here, [1] above, [2] below)
//   ctrl_button_down[2:0]- hall-down calls (same encoding)
//   ctrl_button_in[2:0]  - in-car calls    (same encoding)
//   position[1:0]        - current floor 0..3
//   open                 - door open
//   moving_up/down       - car travelling up/down
//   dir_up               - direction preference, 1 = up
module elevator_ctrl_fsm #(
  parameter int unsigned DOOR_CYCLES   = 8,
  parameter int unsigned TRAVEL_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] ctrl_button_up,
  input  logic [2:0] ctrl_button_down,
  input  logic [2:0] ctrl_button_in,
  output logic [1:0] position,
  output logic       open,
  output logic       moving_up,
  output logic       moving_down,
  output logic       dir_up
);

  localparam int unsigned MAX_CYCLES = (DOOR_CYCLES > TRAVEL_CYCLES) ? DOOR_CYCLES : TRAVEL_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES) + 1;
  localparam logic [CNT_W-1:0] DOOR_LAST = CNT_W'(DOOR_CYCLES - 1);
  localparam logic [CNT_W-1:0] TRAV_LAST = CNT_W'(TRAVEL_CYCLES - 1);
  localparam logic [1:0] TOP_FLOOR    = 2'd3;
  localparam logic [1:0] BOTTOM_FLOOR = 2'd0;

  typedef enum logic [1:0] {IDLE, DOOR, UP, DOWN} state_t;

  state_t           state, state_n;
  logic [1:0]       position_n;
  logic             dir_up_n;
  logic [CNT_W-1:0] door_cnt, door_cnt_n;
  logic [CNT_W-1:0] trav_cnt, trav_cnt_n;

  logic here_c, above_c, below_c;
  logic above_ok_c, below_ok_c;

  // Merge the three call sources; mask requests that would drive past the shaft ends.
  always_comb begin
    here_c     = ctrl_button_up[0] | ctrl_button_down[0] | ctrl_button_in[0];
    above_c    = ctrl_button_up[1] | ctrl_button_down[1] | ctrl_button_in[1];
    below_c    = ctrl_button_up[2] | ctrl_button_down[2] | ctrl_button_in[2];
    above_ok_c = above_c && (position != TOP_FLOOR);
    below_ok_c = below_c && (position != BOTTOM_FLOOR);
  end

  // State, position, preference, counters and registered flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      position    <= 2'd0;
      dir_up      <= 1'b1;
      door_cnt    <= '0;
      trav_cnt    <= '0;
      open        <= 1'b0;
      moving_up   <= 1'b0;
      moving_down <= 1'b0;
    end else begin
      state       <= state_n;
      position    <= position_n;
      dir_up      <= dir_up_n;
      door_cnt    <= door_cnt_n;
      trav_cnt    <= trav_cnt_n;
      open        <= (state_n == DOOR);
      moving_up   <= (state_n == UP);
      moving_down <= (state_n == DOWN);
    end
  end

  // Next-state logic; counters default to zero so they idle at zero outside their state.
  always_comb begin
    state_n    = state;
    position_n = position;
    dir_up_n   = dir_up;
    door_cnt_n = '0;
    trav_cnt_n = '0;
    case (state)
      IDLE: begin
        if (here_c) begin
          state_n = DOOR;
        end else if (dir_up && above_ok_c) begin
          state_n = UP;
        end else if (!dir_up && below_ok_c) begin
          state_n = DOWN;
        end else if (above_ok_c) begin
          state_n  = UP;
          dir_up_n = 1'b1;
        end else if (below_ok_c) begin
          state_n  = DOWN;
          dir_up_n = 1'b0;
        end
      end
      DOOR: begin
        // Timer is not restarted by new here-calls; IDLE always follows.
        if (door_cnt == DOOR_LAST) begin
          state_n = IDLE;
        end else begin
          door_cnt_n = door_cnt + CNT_W'(1);
        end
      end
      UP: begin
        if (trav_cnt == TRAV_LAST) begin
          state_n = IDLE;
          if (position != TOP_FLOOR) position_n = position + 2'd1;
        end else begin
          trav_cnt_n = trav_cnt + CNT_W'(1);
        end
      end
      DOWN: begin
        if (trav_cnt == TRAV_LAST) begin
          state_n = IDLE;
          if (position != BOTTOM_FLOOR) position_n = position - 2'd1;
        end else begin
          trav_cnt_n = trav_cnt + CNT_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_elevator_ctrl_fsm.sv
// Self-checking bench for elevator_ctrl_fsm (DOOR_CYCLES=4, TRAVEL_CYCLES=3).
// A behavioural model predicts each cycle's outputs into a queue at drive
// time; the entry is popped and compared one step after the clock edge.
module tb_elevator_ctrl_fsm;

  localparam int DC = 4;
  localparam int TC = 3;
  localparam int M_IDLE = 0, M_DOOR = 1, M_UP = 2, M_DOWN = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] ctrl_button_up, ctrl_button_down, ctrl_button_in;
  logic [1:0] position;
  logic       open, moving_up, moving_down, dir_up;

  elevator_ctrl_fsm #(.DOOR_CYCLES(DC), .TRAVEL_CYCLES(TC)) dut (
    .clk(clk), .reset(reset),
    .ctrl_button_up(ctrl_button_up), .ctrl_button_down(ctrl_button_down),
    .ctrl_button_in(ctrl_button_in),
    .position(position), .open(open), .moving_up(moving_up),
    .moving_down(moving_down), .dir_up(dir_up)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [5:0] exp_q[$];

  int m_state = M_IDLE, m_pos = 0, m_timer = 0;
  logic m_dir = 1'b1;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, expv, $time);
    end
  endtask

  // Drive one cycle of inputs, predict the resulting outputs, then check them.
  task automatic step(input logic [2:0] up, input logic [2:0] dn, input logic [2:0] inn,
                      input logic rst, input string tag);
    logic here, above, below;
    logic [5:0] got;
    ctrl_button_up = up; ctrl_button_down = dn; ctrl_button_in = inn; reset = rst;
    here  = up[0] | dn[0] | inn[0];
    above = up[1] | dn[1] | inn[1];
    below = up[2] | dn[2] | inn[2];
    if (rst) begin
      m_state = M_IDLE; m_pos = 0; m_dir = 1'b1; m_timer = 0;
    end else begin
      case (m_state)
        M_IDLE: begin
          if (here) begin m_state = M_DOOR; m_timer = DC; end
          else if (m_dir && above && m_pos < 3) begin m_state = M_UP; m_timer = TC; end
          else if (!m_dir && below && m_pos > 0) begin m_state = M_DOWN; m_timer = TC; end
          else if (above && m_pos < 3) begin m_state = M_UP; m_timer = TC; m_dir = 1'b1; end
          else if (below && m_pos > 0) begin m_state = M_DOWN; m_timer = TC; m_dir = 1'b0; end
        end
        M_DOOR: begin
          m_timer--;
          if (m_timer == 0) m_state = M_IDLE;
        end
        M_UP: begin
          m_timer--;
          if (m_timer == 0) begin m_state = M_IDLE; m_pos++; end
        end
        default: begin
          m_timer--;
          if (m_timer == 0) begin m_state = M_IDLE; m_pos--; end
        end
      endcase
    end
    exp_q.push_back({2'(m_pos), m_state == M_DOOR, m_state == M_UP, m_state == M_DOWN, m_dir});
    @(posedge clk);
    #1;
    got = {position, open, moving_up, moving_down, dir_up};
    chk(tag, 8'(got), 8'(exp_q.pop_front()));
  endtask

  initial begin
    int cnt;
    ctrl_button_up = '0; ctrl_button_down = '0; ctrl_button_in = '0; reset = 1'b1;

    // 1: reset, then idle with no calls
    step(3'b000, 3'b000, 3'b000, 1'b1, "t1_rst");
    step(3'b000, 3'b000, 3'b000, 1'b1, "t1_rst");
    chk("t1_rst_vals", 8'({position, open, moving_up, moving_down, dir_up}), 8'b0000_0001);
    for (int i = 0; i < 10; i++) step(3'b000, 3'b000, 3'b000, 1'b0, "t1_idle");

    // 2: call at floor 2 from floor 0, then door service
    cnt = 0;
    for (int i = 0; i < 20 && m_pos != 2; i++) begin
      step(3'b000, 3'b000, 3'b010, 1'b0, "t2_travel");
      if (moving_up) cnt++;
    end
    chk("t2_reach_pos", 8'(position), 8'd2);
    chk("t2_up_cycles", 8'(cnt), 8'd6);
    cnt = 0;
    step(3'b000, 3'b000, 3'b001, 1'b0, "t2_open");
    if (open) cnt++;
    for (int i = 0; i < 6; i++) begin
      step(3'b000, 3'b000, 3'b000, 1'b0, "t2_door");
      if (open) cnt++;
    end
    chk("t2_open_cycles", 8'(cnt), 8'd4);

    // 3: above and below both pending with dir_up=1 -> up first, then down
    for (int i = 0; i < 10 && m_pos != 3; i++) step(3'b010, 3'b000, 3'b100, 1'b0, "t3_up");
    chk("t3_at_top", 8'(position), 8'd3);
    step(3'b000, 3'b000, 3'b100, 1'b0, "t3_turn");
    chk("t3_down_dir", 8'({moving_down, dir_up}), 8'b10);
    for (int i = 0; i < 4; i++) step(3'b000, 3'b000, 3'b000, 1'b0, "t3_hop");
    chk("t3_hop_done", 8'(position), 8'd2);
    for (int i = 0; i < 10 && m_pos != 3; i++) step(3'b000, 3'b000, 3'b010, 1'b0, "t3_back");

    // 4: illegal above request at the top floor is ignored
    for (int i = 0; i < 6; i++) step(3'b000, 3'b000, 3'b010, 1'b0, "t4_illegal");
    chk("t4_stay_top", 8'({position, moving_up}), 8'b110);

    // 5: reset in the middle of an up hop from floor 1
    for (int i = 0; i < 20 && m_pos != 1; i++) step(3'b000, 3'b000, 3'b100, 1'b0, "t5_down");
    chk("t5_at_1", 8'(position), 8'd1);
    step(3'b000, 3'b000, 3'b010, 1'b0, "t5_hop");
    chk("t5_moving", 8'(moving_up), 8'd1);
    step(3'b000, 3'b000, 3'b010, 1'b1, "t5_reset");
    chk("t5_after_rst", 8'({position, open, moving_up, moving_down, dir_up}), 8'b0000_0001);

    // 6: here held high -> 4 open, 1 idle, reopen
    for (int i = 0; i < 12; i++) begin
      step(3'b000, 3'b000, 3'b001, 1'b0, "t6_model");
      chk("t6_open_pat", 8'(open), 8'((i % 5) != 4));
    end

    // 7: mixed hall calls via up/down buttons
    for (int i = 0; i < 30; i++)
      step(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'b000, 1'b0, "t7_rand");

    if (exp_q.size() != 0) chk("sb_drain", 8'(exp_q.size()), 8'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
